// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Owns the program counter, instruction register and operand register.
//   Single-cycle commands from control start a read of mem[pc] over a
//   req/ack handshake. The word lands in the instruction or operand register
//   and pc advances. A fetch that sees no ack within TIMEOUT cycles raises a
//   sticky fault and loads HALT_WORD (instruction) or 0 (operand) instead.
//
// Ports
//   clock, reset         rising-edge clock, async active-low reset
//   fetch_instr          pulse: mem[pc] -> instruction, pc+1
//   fetch_operand        pulse: mem[pc] -> operand, pc+1
//   load_pc              pulse: pc <= operand
//   mem_req/mem_addr     read request and address, held until ack
//   mem_ack/mem_rdata    read data valid and data
//   instruction/operand  registered instruction and operand words
//   pc                   program counter
//   busy                 high while a fetch is outstanding
//   done                 one-cycle completion pulse
//   fault                sticky fetch-timeout flag
//
// state    | meaning
// IDLE     | accepts commands (load_pc > fetch_instr > fetch_operand)
// WAIT_ACK | request outstanding, timeout counter running

module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15,
  parameter logic [15:0]           HALT_WORD  = 16'hF800
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_instr,
  input  logic                  fetch_operand,
  input  logic                  load_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           instruction,
  output logic [15:0]           operand,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Down-counter loaded on request; reaching zero without ack is the
  // TIMEOUT-th wait cycle.
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                  state_q, state_d;
  logic                    tgt_opr_q, tgt_opr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [15:0]             instr_q, instr_d;
  logic [15:0]             opr_q, opr_d;
  logic                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tgt_opr_q <= 1'b0;
      cnt_q     <= '0;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      opr_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_opr_q <= tgt_opr_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      opr_q     <= opr_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_opr_d = tgt_opr_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opr_d     = opr_q;
    req_d     = req_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fault_d   = fault_q;

    unique case (state_q)
      IDLE: begin
        if (load_pc) begin
          pc_d   = ADDR_WIDTH'(opr_q);
          done_d = 1'b1;
        end else if (fetch_instr || fetch_operand) begin
          tgt_opr_d = ~fetch_instr;
          if (fault_q) begin
            // Faulted unit never touches memory again until reset.
            if (fetch_instr) instr_d = HALT_WORD;
            else             opr_d   = '0;
            done_d = 1'b1;
          end else begin
            addr_d  = pc_q;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = TC_LOAD;
            state_d = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        // Ack is checked first so an ack on the terminal cycle still succeeds.
        if (mem_ack) begin
          if (tgt_opr_q) opr_d   = mem_rdata;
          else           instr_d = mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          req_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (tgt_opr_q) opr_d   = '0;
          else           instr_d = HALT_WORD;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          fault_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instruction = instr_q;
  assign operand     = opr_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Randomized command/ack stimulus checked against a transaction-level
//   reference model of pc, instruction, operand and fault, plus per-fetch
//   latency, busy length and request count expectations.

module tb_instruction_fetch_unit;

  localparam int          TIMEOUT   = 15;
  localparam logic [15:0] HALT_WORD = 16'hF800;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_instr, fetch_operand, load_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction, operand, pc;
  logic        busy, done, fault;

  instruction_fetch_unit #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .TIMEOUT    (TIMEOUT),
    .HALT_WORD  (HALT_WORD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_instr   (fetch_instr),
    .fetch_operand (fetch_operand),
    .load_pc       (load_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .operand       (operand),
    .pc            (pc),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] m_pc, m_ir, m_opr;
  logic        m_fault;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_pc"},    32'(pc),          32'(m_pc));
    check_val({tag, "_ir"},    32'(instruction), 32'(m_ir));
    check_val({tag, "_opr"},   32'(operand),     32'(m_opr));
    check_val({tag, "_fault"}, 32'(fault),       32'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 16'h0000; m_opr = 16'h0000; m_fault = 1'b0;
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check_val("idle_done", 32'(done),    32'd0);
    check_val("idle_req",  32'(mem_req), 32'd0);
    check_regs("idle");
  endtask

  // One fetch. d = wait cycles before ack (d >= TIMEOUT means no ack).
  task automatic do_fetch(input bit is_instr, input int d, input logic [15:0] data,
                          input bit inject);
    int          exp_lat, exp_busy, exp_req;
    int          lat, busy_cnt, req_rise;
    bit          prev_req;
    logic [15:0] exp_addr;
    logic [15:0] tgt;

    exp_addr = m_pc;
    if (m_fault) begin
      exp_lat = 1; exp_busy = 0; exp_req = 0;
      tgt = is_instr ? HALT_WORD : 16'h0000;
    end else if (d < TIMEOUT) begin
      exp_lat = d + 2; exp_busy = d + 1; exp_req = 1;
      tgt = data;
      m_pc = m_pc + 16'd1;
    end else begin
      exp_lat = TIMEOUT + 1; exp_busy = TIMEOUT; exp_req = 1;
      tgt = is_instr ? HALT_WORD : 16'h0000;
      m_fault = 1'b1;
    end
    if (is_instr) m_ir = tgt;
    else          m_opr = tgt;

    @(posedge clock); #1;
    fetch_instr   = is_instr;
    fetch_operand = !is_instr;
    @(posedge clock); #1;
    fetch_instr   = 1'b0;
    fetch_operand = 1'b0;

    lat = 0; busy_cnt = 0; req_rise = 0; prev_req = 1'b0;
    for (int k = 0; k < TIMEOUT + 8; k++) begin
      if (busy) busy_cnt++;
      if (mem_req && !prev_req) req_rise++;
      if (mem_req) check_val("addr_hold", 32'(mem_addr), 32'(exp_addr));
      prev_req = mem_req;
      if (done) begin
        lat = k + 1;
        break;
      end
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? data : 16'($urandom);
      if (inject && k == 1) begin
        case ($urandom_range(0, 2))
          0:       fetch_instr   = 1'b1;
          1:       fetch_operand = 1'b1;
          default: load_pc       = 1'b1;
        endcase
      end
      @(posedge clock); #1;
      mem_ack = 1'b0; fetch_instr = 1'b0; fetch_operand = 1'b0; load_pc = 1'b0;
    end

    check_val("latency",  32'(lat),      32'(exp_lat));
    check_val("busy_len", 32'(busy_cnt), 32'(exp_busy));
    check_val("req_cnt",  32'(req_rise), 32'(exp_req));
    check_regs("fetch");
    @(posedge clock); #1;
    check_val("done_1cyc", 32'(done),    32'd0);
    check_val("req_low",   32'(mem_req), 32'd0);
    check_val("busy_low",  32'(busy),    32'd0);
  endtask

  task automatic do_load(input bit also_fetch);
    m_pc = m_opr;
    @(posedge clock); #1;
    load_pc       = 1'b1;
    fetch_instr   = also_fetch;
    fetch_operand = also_fetch ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clock); #1;
    load_pc = 1'b0; fetch_instr = 1'b0; fetch_operand = 1'b0;
    check_val("load_done", 32'(done),    32'd1);
    check_val("load_req",  32'(mem_req), 32'd0);
    check_regs("load");
    @(posedge clock); #1;
    check_val("load_done_1cyc", 32'(done),    32'd0);
    check_val("load_noreq",     32'(mem_req), 32'd0);
    check_val("load_nobusy",    32'(busy),    32'd0);
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_fetch(1'b1, int'($urandom_range(0, 6)), 16'($urandom), 1'($urandom_range(0, 1)));
        4, 5, 6:    do_fetch(1'b0, int'($urandom_range(0, 6)), 16'($urandom), 1'($urandom_range(0, 1)));
        7:          do_load(1'($urandom_range(0, 1)));
        default:    idle_cycles(int'($urandom_range(1, 4)));
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    fetch_instr = 1'b0; fetch_operand = 1'b0; load_pc = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_req",  32'(mem_req),  32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_busy", 32'(busy),     32'd0);
    check_val("rst_done", 32'(done),     32'd0);
    check_regs("rst");
    @(negedge clock);
    reset = 1'b1;

    // first instruction fetch, zero-wait memory
    do_fetch(1'b1, 0, 16'h0800, 1'b0);

    // pc = 5, operand fetch with 3 wait cycles
    do_fetch(1'b0, 0, 16'h0005, 1'b0);
    do_load(1'b0);
    do_fetch(1'b0, 3, 16'h1234, 1'b0);

    // load_pc to 0x0040, then load with a competing fetch
    do_fetch(1'b0, 1, 16'h0040, 1'b0);
    do_load(1'b0);
    do_load(1'b1);

    // pc wrap, command injected while busy
    do_fetch(1'b0, 2, 16'hFFFF, 1'b0);
    do_load(1'b0);
    do_fetch(1'b1, 2, 16'h7A5C, 1'b1);

    // ack on the terminal cycle wins over the timeout
    do_fetch(1'b1, TIMEOUT - 1, 16'h3C3C, 1'b0);

    random_ops(80);

    // timeout, then faulted fetches
    do_fetch(1'b1, TIMEOUT, 16'h0000, 1'b1);
    do_fetch(1'b1, 0, 16'h1111, 1'b0);
    do_fetch(1'b0, 0, 16'h2222, 1'b0);
    random_ops(10);

    // reset while idle clears the fault
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_regs("rst_idle");
    @(negedge clock);
    reset = 1'b1;

    random_ops(10);

    // reset in the middle of a wait
    @(posedge clock); #1;
    fetch_instr = 1'b1;
    @(posedge clock); #1;
    fetch_instr = 1'b0;
    check_val("pre_rst_req", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_val("mid_rst_req",  32'(mem_req), 32'd0);
    check_val("mid_rst_busy", 32'(busy),    32'd0);
    check_regs("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    // late ack after release must be ignored
    @(posedge clock); #1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clock); #1;
    check_val("late_ack_done", 32'(done), 32'd0);
    mem_ack = 1'b0;
    idle_cycles(2);

    random_ops(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the control state machine.
- Owns the program counter, the instruction register and the operand register.
- Fetches 16-bit words from program memory over a req/ack handshake, driven by single-cycle commands from control.
- Presents the instruction word (opcode in [15:11], source mode in [10:9]) and the immediate/address operand to control and the datapath, and performs PC loads for JUMP.

Parameters:
- ADDR_WIDTH, 16, program counter and memory address width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles in WAIT_ACK before a fetch faults (>=1).
- HALT_WORD, 16'hF800, word loaded into instruction on fault (opcode 11111, decoded as halt).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_instr  in  1  command pulse: fetch mem[pc] into instruction, pc+1.
- fetch_operand  in  1  command pulse: fetch mem[pc] into operand, pc+1.
- load_pc  in  1  command pulse: pc <= operand[ADDR_WIDTH-1:0].
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_ack  in  1  memory read data valid.
- mem_rdata  in  16  memory read data.
- instruction  out  16  instruction register.
- operand  out  16  operand (immediate/address) register.
- pc  out  ADDR_WIDTH  program counter.
- busy  out  1  high while a fetch is outstanding.
- done  out  1  one-cycle completion pulse.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; pc=RESET_PC; instruction=0 (NOP); operand=0; mem_req=0; mem_addr=0; busy=0; done=0; fault=0; timeout counter=0.
- All outputs are registered. done defaults to 0 every cycle unless set below.
- States: IDLE, WAIT_ACK.
- IDLE, command priority: load_pc > fetch_instr > fetch_operand. Only one is accepted per cycle; the others are dropped.
- IDLE, load_pc: pc<=operand[ADDR_WIDTH-1:0]; done=1 next cycle; stay IDLE.
- IDLE, fetch_* with fault=0: latch target (IR or OPR); mem_addr<=pc; mem_req<=1; busy<=1; counter<=0; go WAIT_ACK.
- IDLE, fetch_* with fault=1: no memory access. Target <= HALT_WORD (IR) or 0 (OPR); pc unchanged; done=1 next cycle.
- WAIT_ACK: mem_req and mem_addr are held stable until ack.
  - mem_ack=1: target<=mem_rdata; pc<=pc+1 (wraps 2^ADDR_WIDTH-1 -> 0); mem_req<=0; busy<=0; done<=1; go IDLE.
  - mem_ack=0 and counter==TIMEOUT-1: mem_req<=0; busy<=0; fault<=1; done<=1; target<=HALT_WORD (IR) or 0 (OPR); pc unchanged; go IDLE.
  - Otherwise: counter+1.
  - mem_ack and timeout on the same cycle: ack wins, no fault.
- Latency: command at edge N gives mem_req high after N. Ack sampled at edge M gives instruction/pc/done updated after M. Zero-wait memory (ack on first WAIT cycle) completes 2 cycles after the command.
- Commands while busy=1 are ignored, not queued.
- mem_ack while mem_req=0 is ignored.
- instruction and operand hold their values between fetches; only the latched target changes.
- Reset asserted mid-fetch aborts immediately: mem_req drops asynchronously, all registers return to reset values, the fault flag clears.

Test Plan:
- Reset release, mem[0]=16'h0800, ack 1 cycle after req: fetch_instr pulse gives mem_req=1, mem_addr=0; instruction=16'h0800, pc=1, done pulse 2 cycles after command.
- pc=5, fetch_operand, ack after 3 wait cycles with rdata=16'h1234: operand=16'h1234, pc=6, instruction unchanged, busy high exactly 4 cycles.
- operand=16'h0040, load_pc: pc=16'h0040 and done pulse 1 cycle later; no mem_req. Same-cycle load_pc+fetch_instr: only the load is performed.
- pc=16'hFFFF, fetch_instr with ack: pc wraps to 0. fetch_operand pulsed while busy is ignored (single mem_req, single done).
- No ack for TIMEOUT=15 cycles on fetch_instr: mem_req drops, instruction=16'hF800, fault=1, pc unchanged. Next fetch_instr: HALT_WORD with no mem_req, done 1 cycle later.
- reset low during WAIT_ACK: mem_req=0 immediately, pc=RESET_PC, fault=0. A late mem_ack after reset release changes nothing.
